// File: rtl/r2sdf_pkg.sv
// ---------------------------------------------------------------------------
// r2sdf_pkg
// Shared definitions for the R2SDF (DIF) stage sequencing logic:
//   - state_e      : controller state (IDLE / RUN / FLUSH)
//   - delay_len()  : feedback delay length D of a stage, 2^(LOG_N-1-STAGE)
//   - tw_addr()    : frame index -> twiddle ROM address for one stage
// The functions are written on plain ints so a pipeline top level or a
// reference model can reuse them without instantiating any hardware.
// ---------------------------------------------------------------------------
package r2sdf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic int delay_len(input int log_n, input int stage);
    return 1 << (log_n - 1 - stage);
  endfunction

  // ROM entry k holds the twiddle for angle pi*k/2^(log_n-1). Stage s only
  // needs every 2^s-th entry, and only during the first half of each block
  // of 2D samples; in the butterfly half the multiplier is bypassed, so the
  // address is parked at 0.
  function automatic int tw_addr(input int cnt, input int log_n, input int stage);
    int d;
    int mask;
    d    = delay_len(log_n, stage);
    mask = (1 << (log_n - 1)) - 1;
    if ((cnt & d) != 0) begin
      return 0;
    end
    return ((cnt & (d - 1)) << stage) & mask;
  endfunction

endpackage

// File: rtl/r2sdf_stage_ctrl_if.sv
// ---------------------------------------------------------------------------
// r2sdf_stage_ctrl_if
// Bundle between the stream source / stage datapath / twiddle ROM and the
// stage controller.
//   master : stream source side, drives in_valid, in_sof, flush and observes
//            everything the controller produces
//   slave  : the controller itself
// Signals:
//   in_valid, in_sof, flush       source -> controller
//   in_ready                      controller -> source (0 while flushing)
//   step, zero_fill, bf_sel       controller -> datapath
//   rom_addr                      controller -> twiddle ROM (same cycle as step)
//   tw_valid, tw_apply            controller -> multiplier (ROM aligned)
//   sync_err, flush_done          status pulses
//   frame_cnt                     completed input frames (wraps)
// ---------------------------------------------------------------------------
interface r2sdf_stage_ctrl_if #(
  parameter int AW = 7
);

  logic          in_valid;
  logic          in_sof;
  logic          in_ready;
  logic          flush;
  logic          step;
  logic          zero_fill;
  logic          bf_sel;
  logic [AW-1:0] rom_addr;
  logic          tw_valid;
  logic          tw_apply;
  logic          sync_err;
  logic          flush_done;
  logic [15:0]   frame_cnt;

  modport master (
    output in_valid, in_sof, flush,
    input  in_ready, step, zero_fill, bf_sel, rom_addr,
           tw_valid, tw_apply, sync_err, flush_done, frame_cnt
  );

  modport slave (
    input  in_valid, in_sof, flush,
    output in_ready, step, zero_fill, bf_sel, rom_addr,
           tw_valid, tw_apply, sync_err, flush_done, frame_cnt
  );

endinterface

// File: rtl/r2sdf_tw_addr_gen.sv
// ---------------------------------------------------------------------------
// r2sdf_tw_addr_gen
// Purely combinational map from a stage's frame index to its butterfly
// select and twiddle ROM address.
// Ports:
//   cnt      in  LOG_N  sample index within the frame
//   bf_sel   out 1      0 = fill/twiddle phase, 1 = butterfly phase
//   rom_addr out AW     twiddle ROM address (0 during the butterfly phase)
// ---------------------------------------------------------------------------
module r2sdf_tw_addr_gen
  import r2sdf_pkg::*;
#(
  parameter int LOG_N = 8,
  parameter int STAGE = 0,
  parameter int AW    = LOG_N - 1
) (
  input  logic [LOG_N-1:0] cnt,
  output logic             bf_sel,
  output logic [AW-1:0]    rom_addr
);

  assign bf_sel   = cnt[LOG_N-1-STAGE];
  assign rom_addr = AW'(tw_addr(32'(cnt), LOG_N, STAGE));

endmodule

// File: rtl/r2sdf_stage_ctrl.sv
// ---------------------------------------------------------------------------
// r2sdf_stage_ctrl
// Sequencing controller for one radix-2 single-path delay-feedback FFT
// stage. It tracks the sample index inside a frame, drives the butterfly
// select and twiddle ROM address, produces ROM-aligned multiplier strobes,
// and drains the delay line with zero samples after the last frame.
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   bus   slave side of r2sdf_stage_ctrl_if (handshake, datapath and ROM
//         control, status pulses, frame counter)
// ---------------------------------------------------------------------------
module r2sdf_stage_ctrl
  import r2sdf_pkg::*;
#(
  parameter int LOG_N = 8,
  parameter int STAGE = 0,
  parameter int AW    = LOG_N - 1
) (
  input  logic               clk,
  input  logic               rst,
  r2sdf_stage_ctrl_if.slave  bus
);

  localparam int               N          = 1 << LOG_N;
  localparam int               D          = delay_len(LOG_N, STAGE);
  localparam logic [LOG_N-1:0] CNT_LAST   = LOG_N'(N - 1);
  localparam logic [LOG_N-1:0] FCNT_LAST  = LOG_N'(D - 1);

  state_e             state_q, state_d;
  logic [LOG_N-1:0]   cnt_q, cnt_d;
  logic [LOG_N-1:0]   fcnt_q, fcnt_d;
  logic               flush_pend_q, flush_pend_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               tw_valid_q, tw_valid_d;
  logic               tw_apply_q, tw_apply_d;
  logic               sync_err_q, sync_err_d;
  logic               flush_done_q, flush_done_d;

  logic               step;
  logic               bf_sel;
  logic [AW-1:0]      rom_addr;
  logic [LOG_N-1:0]   addr_cnt;

  // A start-of-frame arriving mid-frame resynchronises: that sample is
  // treated as index 0, so the address generator sees 0 instead of cnt_q.
  assign addr_cnt = (state_q == RUN && bus.in_valid && bus.in_sof) ? '0 : cnt_q;

  r2sdf_tw_addr_gen #(
    .LOG_N (LOG_N),
    .STAGE (STAGE),
    .AW    (AW)
  ) u_addr_gen (
    .cnt      (addr_cnt),
    .bf_sel   (bf_sel),
    .rom_addr (rom_addr)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fcnt_d       = fcnt_q;
    flush_pend_d = flush_pend_q | bus.flush;
    frame_cnt_d  = frame_cnt_q;
    sync_err_d   = 1'b0;
    flush_done_d = 1'b0;
    step         = 1'b0;

    case (state_q)
      IDLE: begin
        // Nothing to drain while idle; only a flush seen together with a
        // new frame's sof survives, to be honoured at that frame's end.
        flush_pend_d = 1'b0;
        if (bus.in_valid && bus.in_sof) begin
          step         = 1'b1;
          state_d      = RUN;
          cnt_d        = LOG_N'(1);
          flush_pend_d = bus.flush;
        end
      end

      RUN: begin
        if (bus.in_valid) begin
          step = 1'b1;
          if (bus.in_sof && cnt_q != '0) begin
            sync_err_d = 1'b1;
            cnt_d      = LOG_N'(1);
          end else begin
            cnt_d = cnt_q + LOG_N'(1);
            if (cnt_q == CNT_LAST) begin
              frame_cnt_d = frame_cnt_q + 16'd1;
            end
          end
        end else if (flush_pend_q && cnt_q == '0) begin
          // Only start draining on a frame boundary during an input gap.
          state_d      = FLUSH;
          fcnt_d       = '0;
          flush_pend_d = 1'b0;
        end
      end

      FLUSH: begin
        step   = 1'b1;
        cnt_d  = cnt_q + LOG_N'(1);
        fcnt_d = fcnt_q + LOG_N'(1);
        if (fcnt_q == FCNT_LAST) begin
          state_d      = IDLE;
          cnt_d        = '0;
          fcnt_d       = '0;
          flush_done_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // One-cycle copies line up with the ROM's registered read data.
    tw_valid_d = step;
    tw_apply_d = ~bf_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      fcnt_q       <= '0;
      flush_pend_q <= 1'b0;
      frame_cnt_q  <= '0;
      tw_valid_q   <= 1'b0;
      tw_apply_q   <= 1'b0;
      sync_err_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fcnt_q       <= fcnt_d;
      flush_pend_q <= flush_pend_d;
      frame_cnt_q  <= frame_cnt_d;
      tw_valid_q   <= tw_valid_d;
      tw_apply_q   <= tw_apply_d;
      sync_err_q   <= sync_err_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign bus.in_ready   = (state_q != FLUSH);
  assign bus.step       = step;
  assign bus.zero_fill  = step & (state_q == FLUSH);
  assign bus.bf_sel     = bf_sel;
  assign bus.rom_addr   = rom_addr;
  assign bus.tw_valid   = tw_valid_q;
  assign bus.tw_apply   = tw_apply_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.flush_done = flush_done_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: doc/r2sdf_stage_ctrl.md
Name: r2sdf_stage_ctrl

Overview:
Sequencing controller for one radix-2 single-path delay-feedback (R2SDF, DIF) FFT stage.
- Tracks sample position within a frame and drives the stage butterfly select.
- Drives twiddle-ROM addressing (ROM entry k holds cos/sin of pi·k/2^AW, 1-cycle read latency) and issues a ROM-aligned multiplier-valid.
- Runs a flush sequence that drains the delay line after the last frame.
- One instance per stage; it sits between the stream source and the stage datapath and ROM pair.

Parameters:
LOG_N, 8, log2 of FFT size N; legal 2..12
STAGE, 0, stage index 0..LOG_N-1; delay length D = 2^(LOG_N-1-STAGE)
AW, LOG_N-1, twiddle ROM address width; fixed to LOG_N-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample present
in_sof  in  1  marks first sample of a frame; qualified by in_valid
in_ready  out  1  controller accepts input (0 during FLUSH)
flush  in  1  request drain after last frame; level, latched internally
step  out  1  datapath advance strobe this cycle
zero_fill  out  1  datapath substitutes zero input (flush cycles)
bf_sel  out  1  0 = fill/twiddle phase, 1 = butterfly phase
rom_addr  out  AW  twiddle ROM address, same cycle as step
tw_valid  out  1  step delayed 1 cycle, aligned to ROM qout
tw_apply  out  1  ~bf_sel delayed 1 cycle; 0 = multiplier bypass
sync_err  out  1  1-cycle pulse: in_sof arrived mid-frame
flush_done  out  1  1-cycle pulse at end of FLUSH
frame_cnt  out  16  completed input frames, wraps

Behaviour:
- State encoding: IDLE, RUN, FLUSH.
- Registers: cnt (LOG_N bits, frame index), flush_pend, fcnt (flush counter).
- Reset state: IDLE, cnt=0, flush_pend=0, frame_cnt=0.
- Reset values of outputs: tw_valid=0, tw_apply=0, sync_err=0, flush_done=0; combinational outputs follow IDLE/cnt=0, so in_ready=1, step=0, bf_sel=0, rom_addr=0.
- in_ready = (state != FLUSH).
- Combinational outputs from registered state/cnt:
  - bf_sel = cnt[LOG_N-1-STAGE]
  - rom_addr = bf_sel ? 0 : (cnt mod D) << STAGE, truncated to AW. For STAGE = LOG_N-1, rom_addr is always 0.
- step definition:
  - IDLE: in_valid & in_sof.
  - RUN: in_valid.
  - FLUSH: 1 every cycle.
  - zero_fill = step & (state == FLUSH).
- IDLE: in_valid without in_sof is dropped silently. in_valid & in_sof → RUN; this sample has index 0; cnt becomes 1 next cycle.
- RUN:
  - Each step increments cnt mod N.
  - On wrap N-1→0, frame_cnt increments.
  - in_valid & in_sof with cnt != 0: sync_err pulses next cycle, the sample is treated as index 0 (outputs computed for cnt=0), cnt becomes 1, and frame_cnt does not increment.
  - in_sof with cnt==0 is normal.
- flush handling:
  - flush asserted in any state sets flush_pend.
  - In RUN, with flush_pend, cnt==0 and in_valid==0 → FLUSH; fcnt=0, flush_pend cleared.
  - In IDLE, flush_pend is cleared with no action.
- FLUSH:
  - D step cycles; cnt runs 0..D-1 (bf_sel=0, twiddles issued), in_valid ignored.
  - When fcnt==D-1: → IDLE, cnt=0, flush_done pulses next cycle.
- Latency: tw_valid and tw_apply are registered copies of step and ~bf_sel (1 cycle), matching ROM read latency. There is no other pipeline.
- Simultaneous in_sof & flush: the sof is processed first; flush stays pending until the next frame boundary.
- rst mid-frame or mid-FLUSH: immediate return to reset state and all pending requests dropped.

Decomposition:
- Package r2sdf_pkg:
  - state enum (IDLE/RUN/FLUSH)
  - function clog2-based delay length D(LOG_N, STAGE)
  - function twiddle address mapping (shared with future pipeline top and model).
- One natural sub-module: r2sdf_tw_addr_gen (combinational cnt → bf_sel, rom_addr), reused by the top-level FFT address checker.

Test Plan:
- LOG_N=3, STAGE=0, 8 valid samples with sof on first → bf_sel 0,0,0,0,1,1,1,1; rom_addr 0,1,2,3,0,0,0,0; tw_valid mirrors step +1 cycle; frame_cnt=1.
- LOG_N=3, STAGE=1, 8 samples → bf_sel 0,0,1,1,0,0,1,1; rom_addr 0,2,0,0,0,2,0,0; tw_apply 1,1,0,0,1,1,0,0 delayed 1 cycle.
- Gapped input (in_valid 1-0-1-1-0...), LOG_N=3, STAGE=0 → cnt advances only on valid; step=0 in gaps; tw_valid gaps align 1 cycle later.
- in_sof at index 5 → sync_err pulse, that sample gets rom_addr 0/bf_sel 0, frame_cnt unchanged; the next 7 samples complete the frame normally.
- flush raised at index 3 of a frame, LOG_N=3, STAGE=0:
  - FLUSH is entered only after index 7 and a cycle with in_valid=0.
  - 4 zero_fill steps follow with rom_addr 0,1,2,3 and in_ready=0.
  - flush_done pulses, then state is IDLE with in_ready=1.
- rst asserted during FLUSH cycle 2 → next cycle all reset values, in_ready=1, no flush_done; fresh sof frame runs correctly.
